mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous memory between two requesters: the IF-stage instruction fetch (port I) and the MEM-stage load/store (port D).
- Allows the pipelined datapath to run on a unified instruction/data memory.
- Sequences each access as issue, wait and response, and drives per-stage stall signals to the pipeline register control.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
// Build option: MEM_ARB_RR_EN selects round-robin tie-break.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_CW      = 3;

  function automatic int clamp_lat(input int lat);
    if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
    if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and data ports.
// MEM_ARB_RR_EN: round-robin tie-break instead of data priority.
module mem_arb_pick
  import mem_arb_pkg::*;
`ifndef MEM_ARB_RR_EN
#(
  parameter int STARVE_MAX = 4,
  parameter int SC_W       = 3
)
`endif
(
  input  logic            i_idle,
  input  logic            i_ireq,
  input  logic            i_dreq,
`ifdef MEM_ARB_RR_EN
  input  logic            i_last_owner,
`else
  input  logic [SC_W-1:0] i_starve_cnt,
`endif
  output logic            o_gnt_i,
  output logic            o_gnt_d
);

  logic w_i_first;

`ifdef MEM_ARB_RR_EN
  assign w_i_first = (i_last_owner == OWN_D);
`else
  assign w_i_first = (i_starve_cnt == SC_W'(STARVE_MAX));
`endif

  always_comb begin
    o_gnt_i = 1'b0;
    o_gnt_d = 1'b0;
    if (i_idle) begin
      unique case ({i_ireq, i_dreq})
        2'b10: o_gnt_i = 1'b1;
        2'b01: o_gnt_d = 1'b1;
        2'b11: begin
          o_gnt_i = w_i_first;
          o_gnt_d = !w_i_first;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync memory between fetch (I) and load/store (D).
// Build option: MEM_ARB_RR_EN selects round-robin tie-break.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
)
(
  input  logic              iClkCPU,
  input  logic              iRST,
  input  logic              iIReq,
  input  logic [ADDR_W-1:0] iIAddr,
  output logic              oIGnt,
  output logic              oIRValid,
  output logic [DATA_W-1:0] oIRData,
  input  logic              iDReq,
  input  logic              iDWe,
  input  logic [ADDR_W-1:0] iDAddr,
  input  logic [DATA_W-1:0] iDWData,
  output logic              oDGnt,
  output logic              oDRValid,
  output logic [DATA_W-1:0] oDRData,
  output logic              oMemEn,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  input  logic [DATA_W-1:0] iMemRData,
  output logic              oStallIF,
  output logic              oStallMEM,
  output logic              oBusy
);

  localparam int LAT = clamp_lat(MEM_LAT);
  localparam logic [LAT_CW-1:0] LAT_LAST = LAT_CW'(LAT - 1);
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic [LAT_CW-1:0] r_lat_cnt;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_irdata;
  logic [DATA_W-1:0] r_drdata;

  logic w_idle;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_gnt;
  logic w_last_wait;
  logic w_resp_i;
  logic w_resp_d;

  // Grants are combinational, so they must also be masked during reset.
  assign w_idle      = (r_state == ST_IDLE) && !iRST;
  assign w_gnt       = w_gnt_i | w_gnt_d;
  assign w_last_wait = (r_state == ST_WAIT) &&
                       (r_lat_cnt == LAT_LAST);

`ifdef MEM_ARB_RR_EN
  logic r_last_owner;

  mem_arb_pick u_pick (
    .i_idle       (w_idle),
    .i_ireq       (iIReq),
    .i_dreq       (iDReq),
    .i_last_owner (r_last_owner),
    .o_gnt_i      (w_gnt_i),
    .o_gnt_d      (w_gnt_d)
  );

  always_ff @(posedge iClkCPU or posedge iRST) begin
    if (iRST) begin
      r_last_owner <= OWN_D;
    end else if (w_gnt_i) begin
      r_last_owner <= OWN_I;
    end else if (w_gnt_d) begin
      r_last_owner <= OWN_D;
    end
  end
`else
  logic [SC_W-1:0] r_starve;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .SC_W       (SC_W)
  ) u_pick (
    .i_idle       (w_idle),
    .i_ireq       (iIReq),
    .i_dreq       (iDReq),
    .i_starve_cnt (r_starve),
    .o_gnt_i      (w_gnt_i),
    .o_gnt_d      (w_gnt_d)
  );

  always_ff @(posedge iClkCPU or posedge iRST) begin
    if (iRST) begin
      r_starve <= '0;
    end else if (w_gnt_i) begin
      r_starve <= '0;
    end else if (w_gnt_d && iIReq &&
                 r_starve != SC_W'(STARVE_MAX)) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`endif

  always_ff @(posedge iClkCPU or posedge iRST) begin
    if (iRST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_gnt) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (w_last_wait) w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClkCPU or posedge iRST) begin
    if (iRST) begin
      r_lat_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_lat_cnt <= r_lat_cnt + 1'b1;
    end else begin
      r_lat_cnt <= '0;
    end
  end

  always_ff @(posedge iClkCPU or posedge iRST) begin
    if (iRST) begin
      r_owner  <= OWN_I;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_irdata <= '0;
      r_drdata <= '0;
    end else begin
      if (w_gnt) begin
        r_owner <= w_gnt_d ? OWN_D : OWN_I;
        r_addr  <= w_gnt_d ? iDAddr : iIAddr;
        r_wdata <= w_gnt_d ? iDWData : '0;
        r_we    <= w_gnt_d & iDWe;
      end
      // Each port keeps its last read data until its next response.
      if (w_last_wait) begin
        if (r_owner == OWN_I) begin
          r_irdata <= iMemRData;
        end else begin
          r_drdata <= r_we ? '0 : iMemRData;
        end
      end
    end
  end

  assign w_resp_i = (r_state == ST_RESP) && (r_owner == OWN_I);
  assign w_resp_d = (r_state == ST_RESP) && (r_owner == OWN_D);

  assign oIGnt     = w_gnt_i;
  assign oDGnt     = w_gnt_d;
  assign oIRValid  = w_resp_i;
  assign oDRValid  = w_resp_d;
  assign oIRData   = r_irdata;
  assign oDRData   = r_drdata;
  assign oMemEn    = (r_state == ST_ISSUE);
  assign oMemWe    = (r_state == ST_ISSUE) && r_we;
  assign oMemAddr  = r_addr;
  assign oMemWData = r_wdata;
  assign oStallIF  = iIReq && !iRST && !w_resp_i;
  assign oStallMEM = iDReq && !iRST && !w_resp_d;
  assign oBusy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model (busy window, scheduled reply).
module tb_mem_port_arbiter;

  localparam int LAT  = 1;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        iRST;
  logic        iIReq;
  logic [31:0] iIAddr;
  logic        oIGnt;
  logic        oIRValid;
  logic [31:0] oIRData;
  logic        iDReq;
  logic        iDWe;
  logic [31:0] iDAddr;
  logic [31:0] iDWData;
  logic        oDGnt;
  logic        oDRValid;
  logic [31:0] oDRData;
  logic        oMemEn;
  logic        oMemWe;
  logic [31:0] oMemAddr;
  logic [31:0] oMemWData;
  logic [31:0] iMemRData;
  logic        oStallIF;
  logic        oStallMEM;
  logic        oBusy;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MEM_LAT    (LAT),
    .STARVE_MAX (SMAX)
  ) dut (
    .iClkCPU   (clk),
    .iRST      (iRST),
    .iIReq     (iIReq),
    .iIAddr    (iIAddr),
    .oIGnt     (oIGnt),
    .oIRValid  (oIRValid),
    .oIRData   (oIRData),
    .iDReq     (iDReq),
    .iDWe      (iDWe),
    .iDAddr    (iDAddr),
    .iDWData   (iDWData),
    .oDGnt     (oDGnt),
    .oDRValid  (oDRValid),
    .oDRData   (oDRData),
    .oMemEn    (oMemEn),
    .oMemWe    (oMemWe),
    .oMemAddr  (oMemAddr),
    .oMemWData (oMemWData),
    .iMemRData (iMemRData),
    .oStallIF  (oStallIF),
    .oStallMEM (oStallMEM),
    .oBusy     (oBusy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'h0050_0093 + 32'(i) * 32'h0100_0000;
  endfunction

  // Memory: data visible only in the last cycle of the latency window.
  logic [31:0] tmem [16];
  bit          tmem_init = 1'b0;
  int          pend_cnt  = 0;
  logic [31:0] pend_data = '0;
  logic [31:0] junk      = '0;

  always @(posedge clk) begin
    junk <= $urandom;
    if (!tmem_init) begin
      for (int i = 0; i < 16; i++) tmem[i] <= init_word(i);
      tmem_init <= 1'b1;
    end
    if (iRST) begin
      pend_cnt <= 0;
    end else if (oMemEn) begin
      pend_data <= tmem[oMemAddr[5:2]];
      if (oMemWe) tmem[oMemAddr[5:2]] <= oMemWData;
      pend_cnt <= LAT;
    end else if (pend_cnt > 0) begin
      pend_cnt <= pend_cnt - 1;
    end
  end

  assign iMemRData = (pend_cnt == 1) ? pend_data : junk;

  int checks = 0;
  int errors = 0;

  int          cyc     = 0;
  int          free_at = 0;
  int          starve  = 0;
  bit          last_d  = 1'b1;
  int          iss_cyc = -1;
  int          rsp_cyc = -1;
  bit          rsp_d   = 1'b0;
  bit          iss_we  = 1'b0;
  logic [31:0] iss_addr = '0;
  logic [31:0] iss_wd   = '0;
  logic [31:0] rsp_data = '0;
  logic [31:0] exp_ird  = '0;
  logic [31:0] exp_drd  = '0;
  logic [31:0] ref_mem [16];
  bit          m_gi, m_gd, m_rsp_i, m_rsp_d;
  byte         gseq [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    free_at = cyc;
    starve  = 0;
    last_d  = 1'b1;
    iss_cyc = -1;
    rsp_cyc = -1;
    exp_ird = '0;
    exp_drd = '0;
  endtask

  task automatic reset_check();
    iRST = 1'b1;
    #1;
    chk("rst_ignt", 32'(oIGnt), 0);
    chk("rst_dgnt", 32'(oDGnt), 0);
    chk("rst_irv", 32'(oIRValid), 0);
    chk("rst_drv", 32'(oDRValid), 0);
    chk("rst_ird", oIRData, 0);
    chk("rst_drd", oDRData, 0);
    chk("rst_men", 32'(oMemEn), 0);
    chk("rst_mwe", 32'(oMemWe), 0);
    chk("rst_madr", oMemAddr, 0);
    chk("rst_mwd", oMemWData, 0);
    chk("rst_stif", 32'(oStallIF), 0);
    chk("rst_stmem", 32'(oStallMEM), 0);
    chk("rst_busy", 32'(oBusy), 0);
    @(negedge clk);
    @(negedge clk);
    iRST = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dd);
    bit idle;
    iIReq = ir; iIAddr = ia;
    iDReq = dr; iDWe = dw; iDAddr = da; iDWData = dd;
    #1;
    idle = (cyc >= free_at);
    m_gi = 1'b0;
    m_gd = 1'b0;
    if (idle && (ir || dr)) begin
      if (ir && dr) begin
`ifdef MEM_ARB_RR_EN
        m_gi = last_d;
`else
        m_gi = (starve == SMAX);
`endif
        m_gd = !m_gi;
      end else begin
        m_gi = ir;
        m_gd = dr;
      end
`ifdef MEM_ARB_RR_EN
      last_d = m_gd;
`else
      if (m_gi) starve = 0;
      else if (ir) starve = (starve < SMAX) ? starve + 1 : SMAX;
`endif
      free_at  = cyc + LAT + 3;
      iss_cyc  = cyc + 1;
      rsp_cyc  = cyc + 2 + LAT;
      rsp_d    = m_gd;
      iss_addr = m_gd ? da : ia;
      iss_we   = m_gd && dw;
      iss_wd   = dd;
      rsp_data = iss_we ? 32'h0 : ref_mem[iss_addr[5:2]];
      if (iss_we) ref_mem[iss_addr[5:2]] = dd;
    end
    m_rsp_i = (cyc == rsp_cyc) && !rsp_d;
    m_rsp_d = (cyc == rsp_cyc) && rsp_d;
    if (m_rsp_i) exp_ird = rsp_data;
    if (m_rsp_d) exp_drd = rsp_data;

    chk("ignt", 32'(oIGnt), 32'(m_gi));
    chk("dgnt", 32'(oDGnt), 32'(m_gd));
    chk("busy", 32'(oBusy), 32'(!idle));
    chk("mem_en", 32'(oMemEn), 32'(cyc == iss_cyc));
    chk("mem_we", 32'(oMemWe), 32'((cyc == iss_cyc) && iss_we));
    if (cyc == iss_cyc) chk("mem_addr", oMemAddr, iss_addr);
    if (cyc == iss_cyc && iss_we) chk("mem_wdata", oMemWData, iss_wd);
    chk("irvalid", 32'(oIRValid), 32'(m_rsp_i));
    chk("drvalid", 32'(oDRValid), 32'(m_rsp_d));
    chk("irdata", oIRData, exp_ird);
    chk("drdata", oDRData, exp_drd);
    chk("stall_if", 32'(oStallIF), 32'(ir && !m_rsp_i));
    chk("stall_mem", 32'(oStallMEM), 32'(dr && !m_rsp_d));
    if (oIGnt === 1'b1) gseq.push_back(8'h49);
    if (oDGnt === 1'b1) gseq.push_back(8'h44);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int          i_st, d_st;
    logic [31:0] ia, da, dd;
    logic        dw;
    string       exp_ord;

    iRST = 1'b1;
    iIReq = 1'b0; iIAddr = '0;
    iDReq = 1'b0; iDWe = 1'b0; iDAddr = '0; iDWData = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    iIReq = 1'b1;
    iDReq = 1'b1;
    reset_check();

    // single fetch
    repeat (4) step(1, 32'h0040_0000, 0, 0, 0, 0);
    chk("fetch_data", oIRData, 32'h0050_0093);
    step(0, 0, 0, 0, 0, 0);

    // single store
    repeat (4) step(0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    chk("store_rdata", oDRData, 32'h0);
    step(0, 0, 0, 0, 0, 0);

    // tie: D first, then I from the next IDLE; D reloads stored word
    repeat (4) step(1, 32'h0040_0004, 1, 0, 32'h10, 0);
    chk("tie_load", oDRData, 32'hDEAD_BEEF);
    repeat (4) step(1, 32'h0040_0004, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // reset while a fetch sits in WAIT
    repeat (2) step(1, 32'h0040_0008, 0, 0, 0, 0);
    reset_check();
    repeat (4) step(1, 32'h0040_000C, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // both held high from a fresh reset: grant order
    reset_check();
    gseq.delete();
    repeat (24) step(1, 32'h0040_0010, 1, 0, 32'h14, 0);
`ifdef MEM_ARB_RR_EN
    exp_ord = "IDIDID";
`else
    exp_ord = "DDDDID";
`endif
    chk("order_len", 32'(gseq.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk("grant_order", (i < gseq.size()) ? 32'(gseq[i]) : 32'h0,
          32'(exp_ord[i]));
    end

    // random traffic
    i_st = 0; d_st = 0;
    ia = '0; da = '0; dd = '0; dw = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (i_st == 0 && $urandom_range(0, 2) != 0) begin
        i_st = 1;
        ia = $urandom;
      end else if (i_st == 1 && $urandom_range(0, 9) == 0) begin
        i_st = 0;
      end else if (i_st == 2) begin
        ia = $urandom;
      end
      if (d_st == 0 && $urandom_range(0, 2) != 0) begin
        d_st = 1;
        da = $urandom;
        dd = $urandom;
        dw = 1'($urandom_range(0, 1));
      end else if (d_st == 1 && $urandom_range(0, 9) == 0) begin
        d_st = 0;
      end else if (d_st == 2) begin
        da = $urandom;
        dd = $urandom;
        dw = 1'($urandom_range(0, 1));
      end
      step(i_st != 0, ia, d_st != 0, dw, da, dd);
      if (m_gi) i_st = 2;
      if (m_gd) d_st = 2;
      if (m_rsp_i) i_st = 0;
      if (m_rsp_d) d_st = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
